// File: rtl/mul_div_pkg.sv
// Shared definitions for the mantissa multiplier / divider pair.
package mul_div_pkg;

  // Default mantissa operand width shared by multiplier and divider
  localparam int unsigned MUL_DIV_W = 12;

  // Iteration counter width for a MUL_DIV_W-step divide
  localparam int unsigned DIV_CNT_W = $clog2(MUL_DIV_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/divider_12bit_if.sv
// Operand/result handshake bundle for the restoring divider.
interface divider_12bit_if;
  import mul_div_pkg::*;

  localparam int unsigned N = MUL_DIV_W;

  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   dividend;
  logic [N-1:0]     divisor;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     quotient;
  logic [N-1:0]     remainder;
  logic             div_by_zero;
  logic             overflow;

  // Upstream/downstream side: supplies operands, consumes results
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  // Divider side
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract.
module div_step
  import mul_div_pkg::*;
#(
  parameter int unsigned N = MUL_DIV_W
) (
  input  logic [N:0]   p_i,
  input  logic         bit_i,
  input  logic [N-1:0] divisor_i,
  output logic [N:0]   p_o,
  output logic         q_o
);

  logic [N+1:0] shifted;
  logic [N+1:0] dvs_ext;
  logic [N+1:0] diff;
  logic         ge;

  // Trial subtraction; on a negative result the shifted remainder is kept
  always_comb begin
    shifted = {p_i, bit_i};
    dvs_ext = (N+2)'(divisor_i);
    ge      = (shifted >= dvs_ext);
    diff    = shifted - dvs_ext;
    q_o     = ge;
    p_o     = ge ? (N+1)'(diff) : (N+1)'(shifted);
  end

endmodule

// File: rtl/divider_12bit.sv
// Sequential radix-2 restoring divider: 2N-bit / N-bit -> N-bit quotient and remainder.
module divider_12bit
  import mul_div_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  divider_12bit_if.slave bus
);

  localparam int unsigned N = MUL_DIV_W;

  div_state_t           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [N:0]           p_q, p_d;
  logic [N-1:0]         sh_q, sh_d;
  logic [N-1:0]         dvs_q, dvs_d;
  logic [N-1:0]         quo_q, quo_d;
  logic [N-1:0]         rem_q, rem_d;
  logic                 dbz_q, dbz_d;
  logic                 ovf_q, ovf_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;

  logic [N:0]           step_p;
  logic                 step_q;

  // Low dividend bits leave at the MSB of sh_q while quotient bits enter at its LSB
  div_step #(.N(N)) u_step (
    .p_i       (p_q),
    .bit_i     (sh_q[N-1]),
    .divisor_i (dvs_q),
    .p_o       (step_p),
    .q_o       (step_q)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      p_q         <= '0;
      sh_q        <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      sh_q        <= sh_d;
      dvs_q       <= dvs_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state, datapath update and handshake flags
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    sh_d    = sh_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          if (bus.divisor == '0) begin
            quo_d   = '1;
            rem_d   = '0;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else if (bus.dividend[2*N-1:N] >= bus.divisor) begin
            quo_d   = '1;
            rem_d   = '0;
            ovf_d   = 1'b1;
            state_d = DONE;
          end else begin
            p_d     = {1'b0, bus.dividend[2*N-1:N]};
            sh_d    = bus.dividend[N-1:0];
            dvs_d   = bus.divisor;
            cnt_d   = DIV_CNT_W'(N-1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        p_d   = step_p;
        sh_d  = {sh_q[N-2:0], step_q};
        cnt_d = cnt_q - DIV_CNT_W'(1);
        if (cnt_q == '0) begin
          quo_d   = {sh_q[N-2:0], step_q};
          rem_d   = step_p[N-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_divider_12bit.sv
// Self-checking bench for divider_12bit: directed cases plus randomized traffic.
module tb_divider_12bit;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_pass;

  divider_12bit_if dif ();

  divider_12bit dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: plain integer division with the saturating special cases
  task automatic model(input int unsigned dd, input int unsigned dv,
                       output int unsigned q, output int unsigned r,
                       output bit dbz, output bit ovf);
    dbz = 0; ovf = 0;
    if (dv == 0) begin
      q = 32'hFFF; r = 0; dbz = 1;
    end else if ((dd / 4096) >= dv) begin
      q = 32'hFFF; r = 0; ovf = 1;
    end else begin
      q = dd / dv; r = dd % dv;
    end
  endtask

  // Present operands until accepted; returns with the accept edge just passed
  task automatic send(input logic [23:0] dd, input logic [11:0] dv);
    int guard;
    guard = 0;
    while (!dif.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) chk("send_timeout", 32'(dif.in_ready), 32'd1);
    dif.dividend = dd;
    dif.divisor  = dv;
    dif.in_valid = 1'b1;
    tick();
    dif.in_valid = 1'b0;
  endtask

  // Edges from acceptance (inclusive) until out_valid is seen
  task automatic wait_out(output int lat);
    lat = 1;
    while (!dif.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!dif.out_valid) chk("wait_out_timeout", 32'(dif.out_valid), 32'd1);
  endtask

  initial begin
    int lat;
    int unsigned eq, er;
    bit edbz, eovf;
    logic [23:0] dd;
    logic [11:0] dv, hi;
    int mode;

    n_checks = 0;
    n_pass   = 0;
    rstn          = 1'b1;
    dif.in_valid  = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;
    dif.out_ready = 1'b0;
    tick(); tick();
    rstn = 1'b0;
    tick();

    // Reset state
    chk("rst_in_ready",  32'(dif.in_ready),    32'd1);
    chk("rst_out_valid", 32'(dif.out_valid),   32'd0);
    chk("rst_quotient",  32'(dif.quotient),    32'd0);
    chk("rst_remainder", 32'(dif.remainder),   32'd0);
    chk("rst_dbz",       32'(dif.div_by_zero), 32'd0);
    chk("rst_ovf",       32'(dif.overflow),    32'd0);

    // 1000 / 7 with latency measurement
    dif.out_ready = 1'b0;
    send(24'd1000, 12'd7);
    wait_out(lat);
    chk("basic_latency", 32'(lat), 32'd13);
    chk("basic_q",   32'(dif.quotient),    32'd142);
    chk("basic_r",   32'(dif.remainder),   32'd6);
    chk("basic_dbz", 32'(dif.div_by_zero), 32'd0);
    chk("basic_ovf", 32'(dif.overflow),    32'd0);

    // Hold result: stable outputs, in_ready low, new operands ignored
    for (int i = 0; i < 5; i++) begin
      dif.dividend = 24'd5000;
      dif.divisor  = 12'd3;
      dif.in_valid = 1'b1;
      tick();
      chk("hold_valid", 32'(dif.out_valid), 32'd1);
      chk("hold_ready", 32'(dif.in_ready),  32'd0);
      chk("hold_q",     32'(dif.quotient),  32'd142);
      chk("hold_r",     32'(dif.remainder), 32'd6);
    end
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b1;
    tick();
    dif.out_ready = 1'b0;
    chk("release_valid", 32'(dif.out_valid), 32'd0);
    chk("release_ready", 32'(dif.in_ready),  32'd1);

    // Max-ish quotient case
    send(24'h7FF000, 12'hFFF);
    wait_out(lat);
    chk("big_latency", 32'(lat), 32'd13);
    chk("big_q", 32'(dif.quotient),  32'h7FF);
    chk("big_r", 32'(dif.remainder), 32'h7FF);
    dif.out_ready = 1'b1; tick(); dif.out_ready = 1'b0;

    // Divide by zero
    send(24'hABCDEF, 12'd0);
    wait_out(lat);
    chk("dbz_latency", 32'(lat), 32'd1);
    chk("dbz_flag", 32'(dif.div_by_zero), 32'd1);
    chk("dbz_ovf",  32'(dif.overflow),    32'd0);
    chk("dbz_q",    32'(dif.quotient),    32'hFFF);
    chk("dbz_r",    32'(dif.remainder),   32'd0);
    dif.out_ready = 1'b1; tick(); dif.out_ready = 1'b0;

    // Overflow at the boundary (high half equals divisor)
    send(24'h010000, 12'h010);
    wait_out(lat);
    chk("ovf_latency", 32'(lat), 32'd1);
    chk("ovf_flag", 32'(dif.overflow),    32'd1);
    chk("ovf_dbz",  32'(dif.div_by_zero), 32'd0);
    chk("ovf_q",    32'(dif.quotient),    32'hFFF);
    chk("ovf_r",    32'(dif.remainder),   32'd0);
    dif.out_ready = 1'b1; tick(); dif.out_ready = 1'b0;

    // Reset mid-calculation discards the operation
    send(24'd1000, 12'd7);
    for (int i = 0; i < 5; i++) tick();
    rstn = 1'b1;
    tick();
    rstn = 1'b0;
    chk("midrst_in_ready",  32'(dif.in_ready),    32'd1);
    chk("midrst_out_valid", 32'(dif.out_valid),   32'd0);
    chk("midrst_q",         32'(dif.quotient),    32'd0);
    chk("midrst_r",         32'(dif.remainder),   32'd0);
    chk("midrst_flags",     32'({dif.div_by_zero, dif.overflow}), 32'd0);
    lat = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (dif.out_valid) lat++;
    end
    chk("midrst_no_valid", 32'(lat), 32'd0);
    send(24'd1000, 12'd7);
    wait_out(lat);
    chk("post_rst_q", 32'(dif.quotient),  32'd142);
    chk("post_rst_r", 32'(dif.remainder), 32'd6);
    dif.out_ready = 1'b1; tick(); dif.out_ready = 1'b0;

    // Randomized traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      mode = int'($urandom_range(0, 9));
      if (mode == 0) begin
        dv = 12'd0;
        dd = 24'($urandom);
      end else if (mode == 1) begin
        dv = 12'($urandom_range(1, 4095));
        hi = 12'($urandom_range(32'(dv), 4095));
        dd = {hi, 12'($urandom)};
      end else begin
        dv = 12'($urandom_range(1, 4095));
        hi = 12'($urandom_range(0, 32'(dv) - 1));
        dd = {hi, 12'($urandom)};
      end
      model(32'(dd), 32'(dv), eq, er, edbz, eovf);
      dif.out_ready = 1'($urandom_range(0, 1));
      send(dd, dv);
      wait_out(lat);
      chk("rnd_latency", 32'(lat), (edbz || eovf) ? 32'd1 : 32'd13);
      chk("rnd_q",   32'(dif.quotient),    eq);
      chk("rnd_r",   32'(dif.remainder),   er);
      chk("rnd_dbz", 32'(dif.div_by_zero), 32'(edbz));
      chk("rnd_ovf", 32'(dif.overflow),    32'(eovf));
      if (!edbz && !eovf) begin
        chk("rnd_identity", 32'(dif.quotient) * 32'(dv) + 32'(dif.remainder), 32'(dd));
        chk("rnd_r_lt_d", 32'(32'(dif.remainder) < 32'(dv)), 32'd1);
      end
      if (!dif.out_ready) begin
        for (int s = int'($urandom_range(0, 3)); s > 0; s--) begin
          tick();
          chk("rnd_stall_q", 32'(dif.quotient), eq);
        end
        dif.out_ready = 1'b1;
      end
      tick();
      dif.out_ready = 1'b0;
      chk("rnd_consumed", 32'(dif.out_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/divider_12bit.md
# divider_12bit

Sequential radix-2 restoring divider: 2N-bit dividend ÷ N-bit divisor, N-bit quotient and remainder. It is the inverse counterpart of the mantissa multiplier and serves the FP unit's division path (mantissa quotient, with the dividend typically the pre-shifted numerator mantissa). Operands enter and results leave over valid/ready handshakes, so it stalls cleanly against upstream and downstream pipeline stages.

## Interface
- N, 12, operand width; dividend is 2N bits, divisor/quotient/remainder are N bits

- clk  input  1  clock; all state changes on rising edge
- rstn  input  1  synchronous reset, active-high (1 = reset), sampled on clk rising edge
- in_valid  input  1  dividend/divisor valid
- in_ready  output  1  divider can accept operands
- dividend  input  2N  unsigned dividend
- divisor  input  N  unsigned divisor
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- quotient  output  N  unsigned quotient
- remainder  output  N  unsigned remainder
- div_by_zero  output  1  divisor was 0
- overflow  output  1  quotient does not fit in N bits

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. Handshake in_valid&&in_ready latches operands.
  - divisor==0 → DONE, quotient=all ones, remainder=0, div_by_zero=1.
  - else dividend[2N-1:N] >= divisor → DONE, quotient=all ones, remainder=0, overflow=1.
  - else → CALC, partial remainder P (N+1 bits) = {1'b0, dividend[2N-1:N]}, shift register = dividend[N-1:0], counter = N-1.
- CALC: one step per cycle, MSB first: T = {P[N-1:0], next dividend bit} − {1'b0, divisor}. If T is non-negative, P=T and the quotient bit is 1. Otherwise P is shifted and unchanged, and the quotient bit is 0. Quotient bits shift in at the LSB. At counter==0 the step completes and the FSM → DONE.
- DONE: out_valid=1. quotient, remainder (= P[N-1:0]) and flags are stable while out_valid&&!out_ready. On out_valid&&out_ready → IDLE.
- in_ready=0 in CALC and DONE. in_valid is ignored there and operands are not queued.
- Flags are cleared on each accepted operation.
- Reset in any state → IDLE. All outputs 0, in_ready=1 in the cycle after reset deasserts. An in-flight operation is discarded with no out_valid.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0.
- Normal divide: operands accepted at edge k. CALC occupies cycles k+1..k+N. out_valid is high from the cycle after edge k+N, so latency is N+1 edges (13 for N=12).
- Zero divisor or overflow: out_valid is high the cycle after acceptance, a latency of 1 edge.
- Minimum issue interval is N+2 cycles, because DONE→IDLE costs one cycle when out_ready is held 1. No same-cycle out-accept/in-accept overlap.
- Outputs are registered. There is no combinational path from in_* to out_* or from out_ready to in_ready.

## Structure
- Shared package mul_div_pkg holds:
  - the div_state_t enum {IDLE, CALC, DONE};
  - the default width constant 12 (shared with the multiplier).
- One combinational sub-module, div_step: inputs P, next bit, divisor; outputs new P and quotient bit. The top holds FSM, counter, shift registers and handshake.

## Test plan
- dividend=24'd1000, divisor=12'd7 → quotient=142, remainder=6, flags 0, out_valid exactly 13 edges after acceptance.
- dividend=24'h7FF000, divisor=12'hFFF → quotient=12'h7FF, remainder=12'h7FF.
- divisor=0, any dividend → next cycle out_valid, div_by_zero=1, quotient=12'hFFF, remainder=0. dividend=24'h010000, divisor=12'h010 → overflow=1, same timing.
- Hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0, new in_valid ignored. Raise out_ready → IDLE, then the next operand is accepted.
- Assert rstn mid-CALC (cycle 6) → no out_valid, all outputs 0, in_ready=1 next cycle. A fresh 1000/7 still yields 142 r 6.
- Random back-to-back operands with random out_ready, checked against a reference model: quotient*divisor+remainder==dividend and remainder<divisor when no flag is set.
